// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel-rate divider, h/v counters and a registered
// decode stage producing position, active flag, sync pulses and frame strobes.
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int CLK_DIV  = 2
) (
  input  logic       clk_in,
  input  logic       i_rst,
  output logic       o_pix_stb,
  output logic [9:0] o_x,
  output logic [8:0] o_y,
  output logic       o_active,
  output logic       o_hs,
  output logic       o_vs,
  output logic       o_frame_start,
  output logic       o_animate
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
  localparam logic [9:0] HS_BEG   = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_BEG   = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [9:0] X_MAX    = 10'(H_ACTIVE - 1);
  localparam logic [8:0] Y_MAX    = 9'(V_ACTIVE - 1);

  logic       stb;
  logic [9:0] h_cnt_reg, h_cnt_next;
  logic [9:0] v_cnt_reg, v_cnt_next;
  // Set on the edge that moved the counters, so the decode of the new pair
  // and its o_pix_stb leave the output registers on the same edge.
  logic       adv_reg;

  logic       active_next, hs_next, vs_next, frame_start_next, animate_next;
  logic [9:0] x_next;
  logic [8:0] y_next;

  generate
    if (CLK_DIV == 1) begin : g_no_div
      assign stb = 1'b1;
    end else begin : g_div
      localparam int DIV_W = $clog2(CLK_DIV);
      localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

      logic [DIV_W-1:0] div_reg, div_next;

      always_comb begin
        div_next = div_reg + DIV_W'(1);
        if (div_reg == DIV_LAST) begin
          div_next = '0;
        end
      end

      always_ff @(posedge clk_in or negedge i_rst) begin
        if (!i_rst) begin
          div_reg <= '0;
        end else begin
          div_reg <= div_next;
        end
      end

      assign stb = (div_reg == DIV_LAST);
    end
  endgenerate

  always_comb begin
    h_cnt_next = h_cnt_reg;
    v_cnt_next = v_cnt_reg;
    if (stb) begin
      if (h_cnt_reg == H_LAST) begin
        h_cnt_next = '0;
        v_cnt_next = (v_cnt_reg == V_LAST) ? 10'd0 : v_cnt_reg + 10'd1;
      end else begin
        h_cnt_next = h_cnt_reg + 10'd1;
      end
    end
  end

  always_comb begin
    active_next      = (h_cnt_reg < H_ACT) && (v_cnt_reg < V_ACT);
    hs_next          = !((h_cnt_reg >= HS_BEG) && (h_cnt_reg < HS_END));
    vs_next          = !((v_cnt_reg >= VS_BEG) && (v_cnt_reg < VS_END));
    x_next           = (h_cnt_reg < H_ACT) ? h_cnt_reg : X_MAX;
    y_next           = (v_cnt_reg < V_ACT) ? v_cnt_reg[8:0] : Y_MAX;
    frame_start_next = adv_reg && (h_cnt_reg == 10'd0) && (v_cnt_reg == 10'd0);
    animate_next     = adv_reg && (h_cnt_reg == 10'd0) && (v_cnt_reg == V_ACT);
  end

  always_ff @(posedge clk_in or negedge i_rst) begin
    if (!i_rst) begin
      h_cnt_reg     <= '0;
      v_cnt_reg     <= '0;
      adv_reg       <= 1'b0;
      o_pix_stb     <= 1'b0;
      o_x           <= '0;
      o_y           <= '0;
      o_active      <= 1'b0;
      o_hs          <= 1'b1;
      o_vs          <= 1'b1;
      o_frame_start <= 1'b0;
      o_animate     <= 1'b0;
    end else begin
      h_cnt_reg     <= h_cnt_next;
      v_cnt_reg     <= v_cnt_next;
      adv_reg       <= stb;
      o_pix_stb     <= adv_reg;
      o_x           <= x_next;
      o_y           <= y_next;
      o_active      <= active_next;
      o_hs          <= hs_next;
      o_vs          <= vs_next;
      o_frame_start <= frame_start_next;
      o_animate     <= animate_next;
    end
  end

endmodule
